// File: rtl/vector_memory_sequencer.sv
// Memory-stage access sequencer: splits scalar and vector loads/stores
// into 16-bit memory beats and assembles vector load data.
module vector_memory_sequencer #(
    parameter int DATA_W = 16,
    parameter int VEC_W  = 128,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scalar_load,
    input  logic              scalar_store,
    input  logic              vector_load,
    input  logic              vector_store,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] scalar_wdata,
    input  logic [VEC_W-1:0]  vector_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] scalar_rdata,
    output logic [VEC_W-1:0]  vector_rdata
);
    localparam int BEATS = VEC_W / DATA_W;
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam int LO_W  = $clog2(VEC_W);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
    typedef enum logic [1:0] {OP_SLOAD, OP_SSTORE, OP_VLOAD, OP_VSTORE} op_t;

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [VEC_W-1:0]  wdata_q, wdata_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic [DATA_W-1:0] srdata_q, srdata_d;
    logic [VEC_W-1:0]  vrdata_q, vrdata_d;

    logic            any_req;
    logic            op_vec;
    logic            op_wr;
    logic            last_beat;
    logic [LO_W-1:0] lane_lo;

    assign any_req   = scalar_load | scalar_store | vector_load | vector_store;
    assign op_vec    = (op_q == OP_VLOAD) || (op_q == OP_VSTORE);
    assign op_wr     = (op_q == OP_SSTORE) || (op_q == OP_VSTORE);
    assign last_beat = !op_vec || (beat_q == CNT_W'(BEATS - 1));
    assign lane_lo   = LO_W'(beat_q * DATA_W);

    assign scalar_rdata = srdata_q;
    assign vector_rdata = vrdata_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_SLOAD;
            addr_q   <= '0;
            wdata_q  <= '0;
            beat_q   <= '0;
            srdata_q <= '0;
            vrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            beat_q   <= beat_d;
            srdata_q <= srdata_d;
            vrdata_q <= vrdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        beat_d    = beat_q;
        srdata_d  = srdata_q;
        vrdata_d  = vrdata_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        stall     = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    stall   = 1'b1;
                    state_d = S_ACCESS;
                    beat_d  = '0;
                    addr_d  = addr;
                    // Overlapping requests resolve by fixed priority.
                    if (vector_store) begin
                        op_d    = OP_VSTORE;
                        wdata_d = vector_wdata;
                    end else if (vector_load) begin
                        op_d = OP_VLOAD;
                    end else if (scalar_store) begin
                        op_d    = OP_SSTORE;
                        wdata_d = VEC_W'(scalar_wdata);
                    end else begin
                        op_d = OP_SLOAD;
                    end
                end
            end
            S_ACCESS: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_we   = op_wr;
                mem_addr = addr_q + ADDR_W'(beat_q);
                if (op_wr) begin
                    mem_wdata = wdata_q[lane_lo +: DATA_W];
                end
                if (mem_ack) begin
                    if (!op_wr && op_vec) begin
                        vrdata_d[lane_lo +: DATA_W] = mem_rdata;
                    end else if (!op_wr) begin
                        srdata_d = mem_rdata;
                    end
                    beat_d = beat_q + CNT_W'(1);
                    if (last_beat) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end
endmodule
